// File: rtl/nf_mem_arb.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// instruction-fetch port and the data port, with req/ack handshakes on both.
module nf_mem_arb #(
  parameter int MEM_AW = 8,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_i,
  input  logic [31:0]       addr_i,
  output logic [DW-1:0]     rd_i,
  output logic              ack_i,
  input  logic              req_dm,
  input  logic [31:0]       addr_dm,
  input  logic              we_dm,
  input  logic [DW-1:0]     wd_dm,
  output logic [DW-1:0]     rd_dm,
  output logic              req_ack_dm,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [DW-1:0]     mem_wd,
  input  logic [DW-1:0]     mem_rd
);

  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  state_t state, state_nxt;
  port_t  last_grant, sel, win;
  logic   elig_i, elig_d, grant, capture;

  // Byte-offset and above-depth address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[1:0], addr_i[31:MEM_AW+2],
                              addr_dm[1:0], addr_dm[31:MEM_AW+2]};

  // A port's req is ignored in its own ack cycle so a stale request is never re-granted.
  assign elig_i = req_i  & ~ack_i;
  assign elig_d = req_dm & ~req_ack_dm;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (elig_i || elig_d) state_nxt = CMD;
      CMD:     state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant   = (state == IDLE) && (elig_i || elig_d);
    capture = (state == RESP);
    if (elig_i && elig_d) win = (last_grant == PORT_I) ? PORT_D : PORT_I;
    else if (elig_d)      win = PORT_D;
    else                  win = PORT_I;
  end

  // mem_* are registered on grant, so they are presented to the RAM during CMD.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= PORT_D;
      sel        <= PORT_I;
      ack_i      <= 1'b0;
      req_ack_dm <= 1'b0;
      rd_i       <= '0;
      rd_dm      <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wd     <= '0;
    end else begin
      ack_i      <= 1'b0;
      req_ack_dm <= 1'b0;
      mem_we     <= grant && (win == PORT_D) && we_dm;
      if (grant) begin
        sel <= win;
        if (win == PORT_D) begin
          mem_addr <= addr_dm[MEM_AW+1:2];
          mem_wd   <= wd_dm;
        end else begin
          mem_addr <= addr_i[MEM_AW+1:2];
        end
      end
      if (capture) begin
        last_grant <= sel;
        if (sel == PORT_D) begin
          rd_dm      <= mem_rd;
          req_ack_dm <= 1'b1;
        end else begin
          rd_i  <= mem_rd;
          ack_i <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nf_mem_arb.sv
// Scoreboard bench for nf_mem_arb with a behavioural single-port synchronous RAM.
module tb_nf_mem_arb;

  logic        clk, reset;
  logic        req_i, ack_i, req_dm, we_dm, req_ack_dm, mem_we;
  logic [31:0] addr_i, addr_dm, wd_dm, rd_i, rd_dm, mem_wd, mem_rd;
  logic [7:0]  mem_addr;
  logic        ram_init;

  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];

  typedef struct { bit port; bit wr; logic [31:0] data; } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int total = 0;
  int bad   = 0;

  nf_mem_arb #(.MEM_AW(8), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .req_i(req_i), .addr_i(addr_i), .rd_i(rd_i), .ack_i(ack_i),
    .req_dm(req_dm), .addr_dm(addr_dm), .we_dm(we_dm), .wd_dm(wd_dm),
    .rd_dm(rd_dm), .req_ack_dm(req_ack_dm),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seed(int unsigned k);
    if (k == 2) return 32'h00500093;
    return {8'hA5, k[7:0], 8'h3C, ~k[7:0]};
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 256; k++) ram[k] <= seed(k);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wd;
      mem_rd <= ram[mem_addr];
    end
  end

  // Scoreboard: every ack pops the oldest expectation and checks port and data.
  always @(negedge clk) begin
    if (ack_i || req_ack_dm) begin
      total++;
      if (ack_i && req_ack_dm) begin
        bad++;
        $display("FAIL both_acks ack_i=%b req_ack_dm=%b required at most one high", ack_i, req_ack_dm);
      end
    end
    if (ack_i) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_ack_i unexpected ack_i with empty scoreboard, rd_i=%h", rd_i);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.port !== 1'b0 || rd_i !== mon_e.data) begin
          bad++;
          $display("FAIL sb_ack_i port=I rd_i=%h required port=%0d data=%h", rd_i, mon_e.port, mon_e.data);
        end
      end
    end
    if (req_ack_dm) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_ack_dm unexpected req_ack_dm with empty scoreboard, rd_dm=%h", rd_dm);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.port !== 1'b1 || (!mon_e.wr && rd_dm !== mon_e.data)) begin
          bad++;
          $display("FAIL sb_ack_dm port=D rd_dm=%h required port=%0d wr=%0d data=%h",
                   rd_dm, mon_e.port, mon_e.wr, mon_e.data);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({ack_i, req_ack_dm, mem_we} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl ack_i,req_ack_dm,mem_we=%b required 000", {ack_i, req_ack_dm, mem_we});
    end
    total++;
    if (rd_i !== 32'h0 || rd_dm !== 32'h0) begin
      bad++; $display("FAIL reset_rd rd_i=%h rd_dm=%h required 0", rd_i, rd_dm);
    end
    total++;
    if (mem_addr !== 8'h0 || mem_wd !== 32'h0) begin
      bad++; $display("FAIL reset_mem mem_addr=%h mem_wd=%h required 0", mem_addr, mem_wd);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    int lat = 0, we_hi = 0;
    bit got = 0;
    @(negedge clk);
    req_i = 1'b1; addr_i = 32'h8;
    q.push_back('{port: 1'b0, wr: 1'b0, data: ref_mem[2]});
    while (!got && lat < 10) begin
      @(negedge clk); lat++;
      if (mem_we) we_hi++;
      if (ack_i) begin got = 1; req_i = 1'b0; end
    end
    total++;
    if (!got || lat != 3) begin
      bad++; $display("FAIL fetch_latency got=%0d cycles=%0d required 3", got, lat);
    end
    total++;
    if (we_hi != 0) begin
      bad++; $display("FAIL fetch_mem_we high_cycles=%0d required 0", we_hi);
    end
  endtask

  task automatic test_write_read();
    int lat = 0, we_hi = 0;
    bit got = 0;
    @(negedge clk);
    req_dm = 1'b1; we_dm = 1'b1; addr_dm = 32'h40; wd_dm = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;
    q.push_back('{port: 1'b1, wr: 1'b1, data: 32'h0});
    while (!got && lat < 10) begin
      @(negedge clk); lat++;
      if (mem_we) begin
        we_hi++; total++;
        if (mem_addr !== 8'h10 || mem_wd !== 32'hDEADBEEF) begin
          bad++; $display("FAIL write_cmd mem_addr=%h mem_wd=%h required 10 deadbeef", mem_addr, mem_wd);
        end
      end
      if (req_ack_dm) begin got = 1; req_dm = 1'b0; we_dm = 1'b0; end
    end
    total++;
    if (!got || lat != 3 || we_hi != 1) begin
      bad++; $display("FAIL write_txn got=%0d cycles=%0d we_cycles=%0d required 1/3/1", got, lat, we_hi);
    end
    @(negedge clk);
    req_dm = 1'b1; we_dm = 1'b0; addr_dm = 32'h40;
    q.push_back('{port: 1'b1, wr: 1'b0, data: ref_mem[8'h10]});
    got = 0; lat = 0; we_hi = 0;
    while (!got && lat < 10) begin
      @(negedge clk); lat++;
      if (mem_we) we_hi++;
      if (req_ack_dm) begin got = 1; req_dm = 1'b0; end
    end
    total++;
    if (!got || lat != 3 || we_hi != 0) begin
      bad++; $display("FAIL read_txn got=%0d cycles=%0d we_cycles=%0d required 1/3/0", got, lat, we_hi);
    end
  endtask

  task automatic test_tie();
    int n = 0, c = 0, last = 0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    req_i = 1'b1;  addr_i = 32'h0C;
    req_dm = 1'b1; we_dm = 1'b0; addr_dm = 32'h20;
    for (int k = 0; k < 2; k++) begin
      q.push_back('{port: 1'b0, wr: 1'b0, data: ref_mem[3]});
      q.push_back('{port: 1'b1, wr: 1'b0, data: ref_mem[8]});
    end
    while (n < 4 && c < 30) begin
      @(negedge clk); c++;
      if (ack_i || req_ack_dm) begin
        n++; total++;
        if (c - last != 3) begin
          bad++; $display("FAIL tie_spacing ack#%0d gap=%0d required 3", n, c - last);
        end
        last = c;
        if (n == 4) begin req_i = 1'b0; req_dm = 1'b0; end
      end
    end
    req_i = 1'b0; req_dm = 1'b0;
    total++;
    if (n != 4) begin
      bad++; $display("FAIL tie_count acks=%0d required 4", n);
    end
  endtask

  task automatic test_stale();
    int lat = 0, acks = 0;
    bit got = 0;
    @(negedge clk);
    req_dm = 1'b1; we_dm = 1'b0; addr_dm = 32'h24;
    q.push_back('{port: 1'b1, wr: 1'b0, data: ref_mem[9]});
    while (!got && lat < 10) begin
      @(negedge clk); lat++;
      if (req_ack_dm) got = 1;
    end
    // req_dm stays high through the ack cycle with the same payload.
    @(negedge clk); req_dm = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (req_ack_dm) acks++;
    end
    total++;
    if (!got || acks != 0) begin
      bad++; $display("FAIL stale_regrant first_ack=%0d extra_acks=%0d required 1/0", got, acks);
    end
    req_dm = 1'b1;
    q.push_back('{port: 1'b1, wr: 1'b0, data: ref_mem[9]});
    got = 0; lat = 0;
    while (!got && lat < 10) begin
      @(negedge clk); lat++;
      if (req_ack_dm) begin got = 1; req_dm = 1'b0; end
    end
    total++;
    if (!got || lat != 3) begin
      bad++; $display("FAIL stale_rerequest got=%0d cycles=%0d required 3", got, lat);
    end
  endtask

  task automatic test_wrap();
    int lat = 0;
    bit got = 0, saw_we = 0;
    @(negedge clk);
    req_dm = 1'b1; we_dm = 1'b1; addr_dm = 32'h403; wd_dm = 32'h12345678;
    ref_mem[0] = 32'h12345678;
    q.push_back('{port: 1'b1, wr: 1'b1, data: 32'h0});
    while (!got && lat < 10) begin
      @(negedge clk); lat++;
      if (mem_we) begin
        saw_we = 1; total++;
        if (mem_addr !== 8'h00) begin
          bad++; $display("FAIL wrap_addr mem_addr=%h required 00", mem_addr);
        end
      end
      if (req_ack_dm) begin got = 1; req_dm = 1'b0; we_dm = 1'b0; end
    end
    total++;
    if (!got || !saw_we) begin
      bad++; $display("FAIL wrap_write ack=%0d mem_we_seen=%0d required 1/1", got, saw_we);
    end
    @(negedge clk);
    req_i = 1'b1; addr_i = 32'h0;
    q.push_back('{port: 1'b0, wr: 1'b0, data: ref_mem[0]});
    got = 0; lat = 0;
    while (!got && lat < 10) begin
      @(negedge clk); lat++;
      if (ack_i) begin got = 1; req_i = 1'b0; end
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL wrap_read timeout cycles=%0d required ack", lat);
    end
  endtask

  task automatic test_reset_mid();
    int c = 0, acks = 0, n = 0;
    bit first_i = 0;
    @(negedge clk);
    req_dm = 1'b1; we_dm = 1'b1; addr_dm = 32'h80; wd_dm = 32'hCAFEF00D;
    while (!mem_we && c < 10) begin @(negedge clk); c++; end
    total++;
    if (!mem_we) begin
      bad++; $display("FAIL midreset_cmd mem_we=%b required 1 within 10 cycles", mem_we);
    end
    // The RAM still commits the write on the edge where reset is sampled.
    ref_mem[8'h20] = 32'hCAFEF00D;
    reset = 1'b1; req_dm = 1'b0; we_dm = 1'b0;
    @(negedge clk);
    total++;
    if (mem_we !== 1'b0) begin
      bad++; $display("FAIL midreset_we mem_we=%b required 0", mem_we);
    end
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack_i || req_ack_dm) acks++;
    end
    total++;
    if (acks != 0) begin
      bad++; $display("FAIL midreset_noack acks=%0d required 0", acks);
    end
    req_i = 1'b1;  addr_i = 32'h10;
    req_dm = 1'b1; we_dm = 1'b0; addr_dm = 32'h14;
    q.push_back('{port: 1'b0, wr: 1'b0, data: ref_mem[4]});
    q.push_back('{port: 1'b1, wr: 1'b0, data: ref_mem[5]});
    c = 0;
    while (n < 2 && c < 20) begin
      @(negedge clk); c++;
      if (ack_i || req_ack_dm) begin
        n++;
        if (n == 1) first_i = ack_i;
      end
      if (ack_i)      req_i  = 1'b0;
      if (req_ack_dm) req_dm = 1'b0;
    end
    req_i = 1'b0; req_dm = 1'b0;
    total++;
    if (n != 2 || !first_i) begin
      bad++; $display("FAIL midreset_tie acks=%0d first_is_i=%0d required 2/1", n, first_i);
    end
  endtask

  initial begin
    reset = 1'b1; ram_init = 1'b1;
    req_i = 1'b0; addr_i = '0; req_dm = 1'b0; addr_dm = '0; we_dm = 1'b0; wd_dm = '0;
    for (int k = 0; k < 256; k++) ref_mem[k] = seed(k);
    repeat (2) @(negedge clk);
    ram_init = 1'b0;
    test_reset();
    test_single_fetch();
    test_write_read();
    test_tie();
    test_stale();
    test_wrap();
    test_reset_mid();
    repeat (6) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL sb_leftover pending=%0d required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
